// File: rtl/dma_seq_state_reg.sv
`default_nettype none
// ============================================================================
// dma_seq_state_reg : registered state and address-control half of the DMA
//                     sequencer (present-state latch, pointer, X/Y counters)
// Rev 1.0
// ============================================================================
module dma_seq_state_reg #(
   parameter int AW        = 16,
   parameter int CW        = 8,
   parameter int PAGE_BITS = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic          rmw_cfg,
   input  logic [AW-1:0] base_addr,
   input  logic [AW-1:0] stride,
   input  logic [CW-1:0] xlen,
   input  logic [CW-1:0] ylen,
   input  logic          dmnst3B,
   input  logic          dmnst2B,
   input  logic          dmnst1B,
   input  logic          dmnst0B,
   input  logic          adctlp2B,
   input  logic          adctlp1B,
   input  logic          adctlp0B,
   input  logic          mem_rdy,
   output logic          dmpst3,
   output logic          dmpst2,
   output logic          dmpst1,
   output logic          dmpst0,
   output logic          xskip,
   output logic          yskip,
   output logic          page,
   output logic          rmwB,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic          busy,
   output logic          done
);

   localparam int HW = AW - PAGE_BITS;

   localparam logic [2:0] OP_HOLD  = 3'd0;
   localparam logic [2:0] OP_LOAD  = 3'd1;
   localparam logic [2:0] OP_RD    = 3'd2;
   localparam logic [2:0] OP_WR    = 3'd3;
   localparam logic [2:0] OP_ROW   = 3'd4;
   localparam logic [2:0] OP_PAGE  = 3'd5;
   localparam logic [2:0] OP_WRINC = 3'd6;
   localparam logic [2:0] OP_ERR   = 3'd7;

   localparam logic [3:0]    C_IDLE     = 4'd0;
   localparam logic [HW-1:0] C_HI_ONE   = HW'(1);
   localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);
   localparam logic [AW-1:0] C_ADDR_ONE = AW'(1);

   logic [3:0]    st_q,   st_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [CW-1:0] xcnt_q, xcnt_d;
   logic [CW-1:0] ycnt_q, ycnt_d;
   logic          rmw_q,  rmw_d;
   logic          err_q,  err_d;
   logic          done_q, done_d;

   logic [3:0]    w_ns;
   logic [2:0]    w_op;
   logic          w_busy;
   logic          w_access;
   logic          w_write;
   logic          w_stall;
   logic          w_start;
   logic          w_adv;
   logic          w_op_en;
   logic [HW-1:0] w_page_hi;

   assign w_ns   = ~{dmnst3B, dmnst2B, dmnst1B, dmnst0B};
   assign w_op   = ~{adctlp2B, adctlp1B, adctlp0B};
   assign w_busy = (st_q != C_IDLE);

   assign w_access = (w_op == OP_RD) | (w_op == OP_WR) | (w_op == OP_WRINC);
   assign w_write  = (w_op == OP_WR) | (w_op == OP_WRINC);
   assign w_stall  = mem_req & ~mem_rdy;

   // The load issued alongside an accepted start executes at that same edge.
   assign w_start = ~w_busy & start & ~abort;
   assign w_adv   = w_busy & ~w_stall & ~abort;
   assign w_op_en = w_start | w_adv;

   assign w_page_hi = addr_q[AW-1:PAGE_BITS] + C_HI_ONE;

   always_comb begin
      st_d   = st_q;
      addr_d = addr_q;
      xcnt_d = xcnt_q;
      ycnt_d = ycnt_q;
      rmw_d  = rmw_q;
      err_d  = err_q;
      done_d = 1'b0;

      if (abort) begin
         st_d = C_IDLE;
      end else if (w_start) begin
         st_d  = w_ns;
         rmw_d = rmw_cfg;
      end else if (w_adv) begin
         st_d   = w_ns;
         done_d = (w_ns == C_IDLE);
      end

      if (w_op_en) begin
         case (w_op)
            OP_LOAD: begin
               addr_d = base_addr;
               xcnt_d = xlen;
               ycnt_d = ylen;
            end
            OP_RD, OP_WRINC: begin
               addr_d = addr_q + C_ADDR_ONE;
               xcnt_d = xcnt_q - C_CNT_ONE;
            end
            OP_ROW: begin
               addr_d = addr_q + stride;
               xcnt_d = xlen;
               ycnt_d = ycnt_q - C_CNT_ONE;
            end
            OP_PAGE: begin
               addr_d = {w_page_hi, {PAGE_BITS{1'b0}}};
            end
            OP_ERR: begin
               err_d = 1'b1;
            end
            default: begin
               addr_d = addr_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q   <= C_IDLE;
         addr_q <= '0;
         xcnt_q <= '0;
         ycnt_q <= '0;
         rmw_q  <= 1'b0;
         err_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         addr_q <= addr_d;
         xcnt_q <= xcnt_d;
         ycnt_q <= ycnt_d;
         rmw_q  <= rmw_d;
         err_q  <= err_d;
         done_q <= done_d;
      end
   end

   assign {dmpst3, dmpst2, dmpst1, dmpst0} = st_q;

   assign xskip    = (xcnt_q == '0);
   assign yskip    = (ycnt_q == '0);
   assign page     = &addr_q[PAGE_BITS-1:0];
   assign rmwB     = ~rmw_q;
   assign mem_req  = w_busy & w_access;
   assign mem_we   = mem_req & w_write;
   assign mem_addr = addr_q;
   assign busy     = w_busy;
   assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_seq_state_reg.sv
`default_nettype none
// ============================================================================
// tb_dma_seq_state_reg : directed and randomized bench for dma_seq_state_reg
// Rev 1.0
// ============================================================================
module tb_dma_seq_state_reg;

   logic        clk = 1'b0;
   logic        rst_n, start, abort, rmw_cfg, mem_rdy;
   logic [15:0] base_addr, stride;
   logic [7:0]  xlen, ylen;
   logic [3:0]  t_ns;
   logic [2:0]  t_op;
   logic        dmnst3B, dmnst2B, dmnst1B, dmnst0B;
   logic        adctlp2B, adctlp1B, adctlp0B;
   logic        dmpst3, dmpst2, dmpst1, dmpst0;
   logic        xskip, yskip, page, rmwB, mem_req, mem_we, busy, done;
   logic [15:0] mem_addr;

   assign {dmnst3B, dmnst2B, dmnst1B, dmnst0B} = ~t_ns;
   assign {adctlp2B, adctlp1B, adctlp0B}       = ~t_op;

   always #5 clk = ~clk;

   dma_seq_state_reg #(.AW(16), .CW(8), .PAGE_BITS(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .rmw_cfg(rmw_cfg),
      .base_addr(base_addr), .stride(stride), .xlen(xlen), .ylen(ylen),
      .dmnst3B(dmnst3B), .dmnst2B(dmnst2B), .dmnst1B(dmnst1B), .dmnst0B(dmnst0B),
      .adctlp2B(adctlp2B), .adctlp1B(adctlp1B), .adctlp0B(adctlp0B),
      .mem_rdy(mem_rdy),
      .dmpst3(dmpst3), .dmpst2(dmpst2), .dmpst1(dmpst1), .dmpst0(dmpst0),
      .xskip(xskip), .yskip(yskip), .page(page), .rmwB(rmwB),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .busy(busy), .done(done)
   );

   int n_chk = 0;
   int n_err = 0;

   // reference state, plain integers
   int m_st, m_addr, m_x, m_y, m_rmw, m_err, m_done;
   bit m_valid = 1'b0;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int cur_st();
      return int'({dmpst3, dmpst2, dmpst1, dmpst0});
   endfunction

   function automatic bit is_access(input int op);
      return (op == 2) || (op == 3) || (op == 6);
   endfunction

   task automatic compare_all();
      int  op;
      bit  req;
      op  = int'(t_op);
      req = (m_st != 0) && is_access(op);
      check("dmpst",    cur_st(),         m_st);
      check("mem_addr", int'(mem_addr),   m_addr);
      check("xskip",    int'(xskip),      int'(m_x == 0));
      check("yskip",    int'(yskip),      int'(m_y == 0));
      check("page",     int'(page),       int'((m_addr % 256) == 255));
      check("rmwB",     int'(rmwB),       int'(m_rmw == 0));
      check("mem_req",  int'(mem_req),    int'(req));
      check("mem_we",   int'(mem_we),     int'(req && (op == 3 || op == 6)));
      check("busy",     int'(busy),       int'(m_st != 0));
      check("done",     int'(done),       m_done);
      check("err_flag", int'(dut.err_q),  m_err);
   endtask

   task automatic apply_op(input int op, inout int a, inout int x, inout int y, inout int e);
      case (op)
         1: begin a = int'(base_addr); x = int'(xlen); y = int'(ylen); end
         2, 6: begin a = (a + 1) % 65536; x = (x + 255) % 256; end
         4: begin a = (a + int'(stride)) % 65536; x = int'(xlen); y = (y + 255) % 256; end
         5: a = (((a / 256) + 1) * 256) % 65536;
         7: e = 1;
         default: ;
      endcase
   endtask

   // one clock: compare outputs against the model, advance model across the edge
   task automatic cycle();
      int  n_st, n_a, n_x, n_y, n_r, n_e, n_d;
      int  op;
      bit  stall;
      #1;
      if (m_valid) compare_all();
      op    = int'(t_op);
      stall = (m_st != 0) && is_access(op) && !mem_rdy;
      n_st = m_st; n_a = m_addr; n_x = m_x; n_y = m_y; n_r = m_rmw; n_e = m_err; n_d = 0;
      if (!rst_n) begin
         n_st = 0; n_a = 0; n_x = 0; n_y = 0; n_r = 0; n_e = 0;
      end else if (abort) begin
         n_st = 0;
      end else if (m_st == 0) begin
         if (start) begin
            n_st = int'(t_ns);
            n_r  = int'(rmw_cfg);
            apply_op(op, n_a, n_x, n_y, n_e);
         end
      end else if (!stall) begin
         n_st = int'(t_ns);
         n_d  = int'(t_ns == 4'd0);
         apply_op(op, n_a, n_x, n_y, n_e);
      end
      @(posedge clk);
      if (!rst_n) m_valid = 1'b1;
      m_st = n_st; m_addr = n_a; m_x = n_x; m_y = n_y; m_rmw = n_r; m_err = n_e; m_done = n_d;
      #1;
   endtask

   task automatic set_in(input bit s, input bit ab, input bit rmw, input int ns, input int op, input bit rdy);
      start   = s;
      abort   = ab;
      rmw_cfg = rmw;
      t_ns    = 4'(ns);
      t_op    = 3'(op);
      mem_rdy = rdy;
   endtask

   initial begin
      rst_n = 1'b0; base_addr = 16'h5A5A; stride = 16'h0101; xlen = 8'h33; ylen = 8'h44;
      set_in(1'b1, 1'b0, 1'b1, 9, 2, 1'b0);
      cycle();
      cycle();
      check("rst_dmpst", cur_st(), 0);
      check("rst_xskip", int'(xskip), 1);
      check("rst_yskip", int'(yskip), 1);
      check("rst_rmwB",  int'(rmwB), 1);
      check("rst_busy",  int'(busy), 0);
      check("rst_page",  int'(page), 0);
      rst_n = 1'b1;

      // start with load
      base_addr = 16'h00FE; xlen = 8'd2; ylen = 8'd1;
      set_in(1'b1, 1'b0, 1'b1, 5, 1, 1'b1);
      cycle();
      check("start_st",    cur_st(), 5);
      check("start_addr",  int'(mem_addr), 16'h00FE);
      check("start_xskip", int'(xskip), 0);
      check("start_yskip", int'(yskip), 0);
      check("start_busy",  int'(busy), 1);
      check("start_rmwB",  int'(rmwB), 0);

      // read held off by three not-ready cycles
      set_in(1'b0, 1'b0, 1'b0, 6, 2, 1'b0);
      repeat (3) begin
         cycle();
         check("stall_st",   cur_st(), 5);
         check("stall_req",  int'(mem_req), 1);
         check("stall_addr", int'(mem_addr), 16'h00FE);
      end
      mem_rdy = 1'b1;
      cycle();
      check("rd_st",   cur_st(), 6);
      check("rd_addr", int'(mem_addr), 16'h00FF);
      check("rd_page", int'(page), 1);

      // row advance across the top of the address space
      base_addr = 16'hFFF0; stride = 16'h0020;
      set_in(1'b0, 1'b0, 1'b0, 3, 1, 1'b1);
      cycle();
      set_in(1'b0, 1'b0, 1'b0, 3, 4, 1'b1);
      cycle();
      check("row_addr",  int'(mem_addr), 16'h0010);
      check("row_xskip", int'(xskip), 0);
      check("row_yskip", int'(yskip), 1);
      cycle();
      check("row2_addr",  int'(mem_addr), 16'h0030);
      check("row2_yskip", int'(yskip), 0);

      // page fixup, then completion
      base_addr = 16'h12FF;
      set_in(1'b0, 1'b0, 1'b0, 3, 1, 1'b1);
      cycle();
      set_in(1'b0, 1'b0, 1'b0, 7, 5, 1'b1);
      cycle();
      check("pg_addr", int'(mem_addr), 16'h1300);
      set_in(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
      cycle();
      check("cmp_st",   cur_st(), 0);
      check("cmp_done", int'(done), 1);
      check("cmp_busy", int'(busy), 0);
      cycle();
      check("cmp_done_end", int'(done), 0);

      // abort during a stalled write, then start+abort together in idle
      base_addr = 16'h0100;
      set_in(1'b1, 1'b0, 1'b0, 2, 1, 1'b1);
      cycle();
      set_in(1'b0, 1'b0, 1'b0, 4, 3, 1'b0);
      cycle();
      check("wr_req", int'(mem_req), 1);
      check("wr_we",  int'(mem_we), 1);
      abort = 1'b1;
      cycle();
      check("ab_st",   cur_st(), 0);
      check("ab_req",  int'(mem_req), 0);
      check("ab_done", int'(done), 0);
      set_in(1'b1, 1'b1, 1'b0, 7, 1, 1'b1);
      base_addr = 16'hBEEF;
      cycle();
      check("ab_idle_st",   cur_st(), 0);
      check("ab_idle_addr", int'(mem_addr), 16'h0100);
      set_in(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
      cycle();

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         int op;
         rst_n     = ($urandom_range(0, 99) != 0);
         start     = 1'($urandom_range(0, 1));
         abort     = ($urandom_range(0, 19) == 0);
         rmw_cfg   = 1'($urandom_range(0, 1));
         mem_rdy   = ($urandom_range(0, 3) != 0);
         base_addr = ($urandom_range(0, 1) == 0) ? 16'($urandom) : {8'($urandom), 8'hFD + 8'($urandom_range(0, 2))};
         stride    = 16'($urandom);
         xlen      = 8'($urandom_range(0, 3));
         ylen      = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 2));
         t_ns      = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         op        = int'($urandom_range(0, 7));
         if (op == 7 && $urandom_range(0, 7) != 0) op = 2;
         t_op      = 3'(op);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
